// File: rtl/systolic_pkg.sv
// systolic_pkg: state encoding and accumulator sizing shared by the systolic
// multiplier and its processing elements.
package systolic_pkg;
   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
   function automatic int ACC_W(input int dw, input int n);
      return 2 * dw + $clog2(n);
   endfunction
endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: output-stationary multiply-accumulate cell that forwards its
// A operand rightwards and its B operand downwards with a one-cycle hop.
module systolic_pe
   import systolic_pkg::*;
#(
   parameter int DW = 8,
   parameter int AW = ACC_W(8, 8)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic signed [DW-1:0] a_in,
   input  logic signed [DW-1:0] b_in,
   output logic signed [DW-1:0] a_out,
   output logic signed [DW-1:0] b_out,
   output logic signed [AW-1:0] acc
);
   logic signed [DW-1:0]   a_q, a_d, b_q, b_d;
   logic signed [AW-1:0]   acc_q, acc_d;
   logic signed [2*DW-1:0] prod;
   always_comb begin
      prod  = a_in * b_in;
      a_d   = clr ? '0 : a_in;
      b_d   = clr ? '0 : b_in;
      acc_d = clr ? '0 : acc_q + AW'(prod);
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
      end
   end
   assign a_out = a_q;
   assign b_out = b_q;
   assign acc   = acc_q;
endmodule

// File: rtl/systolic_matrix_multiplier.sv
// systolic_matrix_multiplier: one-shot C = A x B on an MxP output-stationary
// PE array, fed with a skewed wavefront from operands captured at start.
module systolic_matrix_multiplier
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int RESULT_WIDTH = 16,
   parameter int M            = 8,
   parameter int N            = 8,
   parameter int P            = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [M*N*DATA_WIDTH-1:0]        matrix_a,
   input  logic [N*P*DATA_WIDTH-1:0]        matrix_b,
   output logic                             done,
   output logic [M*P*RESULT_WIDTH-1:0]      result_c
);
   localparam int DW = DATA_WIDTH;
   localparam int RW = RESULT_WIDTH;
   localparam int AW = ACC_W(DW, N);
   localparam int CW = $clog2(N + M + P);
   // One edge past the final feed so the last accumulation has landed.
   localparam logic [CW-1:0] LAST = CW'(N + M + P - 2);

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  done_q, done_d, clr, busy;
   logic [M*N*DW-1:0]     a_cap_q, a_cap_d;
   logic [N*P*DW-1:0]     b_cap_q, b_cap_d;
   logic [M*P*RW-1:0]     result_q, result_d;
   logic signed [DW-1:0]  a_in_w [M][P];
   logic signed [DW-1:0]  b_in_w [M][P];
   logic signed [DW-1:0]  a_h [M][P];
   logic signed [DW-1:0]  b_v [M][P];
   logic signed [AW-1:0]  acc_w [M][P];

   assign busy = state_q == COMPUTE;

   // Row i sees A[i][t-i] and column j sees B[t-j][j]; interior links are PE hops.
   always_comb begin
      for (int i = 0; i < M; i++) begin
         a_in_w[i][0] = '0;
         for (int k = 0; k < N; k++)
            if (busy && cnt_q == CW'(i + k)) a_in_w[i][0] = a_cap_q[(i*N+k)*DW +: DW];
         for (int j = 1; j < P; j++) a_in_w[i][j] = a_h[i][j-1];
      end
      for (int j = 0; j < P; j++) begin
         b_in_w[0][j] = '0;
         for (int k = 0; k < N; k++)
            if (busy && cnt_q == CW'(j + k)) b_in_w[0][j] = b_cap_q[(k*P+j)*DW +: DW];
         for (int i = 1; i < M; i++) b_in_w[i][j] = b_v[i-1][j];
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done_d   = done_q;
      result_d = result_q;
      a_cap_d  = a_cap_q;
      b_cap_d  = b_cap_q;
      clr      = 1'b0;
      if (!busy && start) begin
         state_d = COMPUTE;
         cnt_d   = '0;
         done_d  = 1'b0;
         clr     = 1'b1;
         a_cap_d = matrix_a;
         b_cap_d = matrix_b;
      end else if (busy) begin
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
            for (int i = 0; i < M; i++)
               for (int j = 0; j < P; j++) result_d[(i*P+j)*RW +: RW] = RW'(acc_w[i][j]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
         a_cap_q  <= '0;
         b_cap_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         result_q <= result_d;
         a_cap_q  <= a_cap_d;
         b_cap_q  <= b_cap_d;
      end
   end

   for (genvar r = 0; r < M; r++) begin : g_row
      for (genvar c = 0; c < P; c++) begin : g_col
         systolic_pe #(.DW(DW), .AW(AW)) u_pe (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .a_in  (a_in_w[r][c]),
            .b_in  (b_in_w[r][c]),
            .a_out (a_h[r][c]),
            .b_out (b_v[r][c]),
            .acc   (acc_w[r][c])
         );
      end
   end

   assign done     = done_q;
   assign result_c = result_q;
endmodule

// File: tb/tb_systolic_matrix_multiplier.sv
// tb_systolic_matrix_multiplier: directed vectors and corner-case sequences
// for the 8x8x8 multiplier plus a 2x3x4 parameter override.
module tb_systolic_matrix_multiplier;
   logic          clk = 1'b0, rst = 1'b0, start = 1'b0, start_s = 1'b0;
   logic [511:0]  ma = '0, mb = '0;
   logic          done, done_s;
   logic [1023:0] rc;
   logic [47:0]   sa = '0;
   logic [95:0]   sb = '0;
   logic [127:0]  rs;
   int            checks = 0, failures = 0, lat;

   typedef struct {
      string         nm;
      logic [511:0]  a, b;
      logic [1023:0] exp;
   } vec_t;
   vec_t tv [4];

   always #5 clk = ~clk;

   systolic_matrix_multiplier dut (
      .clk(clk), .rst(rst), .start(start), .matrix_a(ma), .matrix_b(mb),
      .done(done), .result_c(rc)
   );
   systolic_matrix_multiplier #(.M(2), .N(3), .P(4)) dut_s (
      .clk(clk), .rst(rst), .start(start_s), .matrix_a(sa), .matrix_b(sb),
      .done(done_s), .result_c(rs)
   );

   function automatic logic [511:0] rnd512();
      logic [511:0] v;
      for (int w = 0; w < 16; w++) v[w*32 +: 32] = $urandom();
      return v;
   endfunction

   function automatic logic [1023:0] model(input logic [511:0] a, b, input int m, n, p);
      logic [1023:0] c = '0;
      for (int i = 0; i < m; i++)
         for (int j = 0; j < p; j++) begin
            int s = 0;
            for (int k = 0; k < n; k++)
               s += int'(signed'(a[(i*n+k)*8 +: 8])) * int'(signed'(b[(k*p+j)*8 +: 8]));
            c[(i*p+j)*16 +: 16] = s[15:0];
         end
      return c;
   endfunction

   task automatic chk_int(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_mat(input string nm, input logic [1023:0] act, input logic [1023:0] exp, input int elems);
      int bad = -1;
      checks++;
      for (int e = elems - 1; e >= 0; e--) if (act[e*16 +: 16] !== exp[e*16 +: 16]) bad = e;
      if (bad >= 0) begin
         failures++;
         $display("FAIL %s: element %0d got %h expected %h", nm, bad, act[bad*16 +: 16], exp[bad*16 +: 16]);
      end
   endtask

   task automatic pulse(input logic [511:0] a, input logic [511:0] b);
      ma = a;
      mb = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      ma = rnd512();
      mb = rnd512();
   endtask

   task automatic wait_done(output int l);
      l = 0;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         #1;
         if (done) begin
            l = c;
            break;
         end
      end
   endtask

   initial begin
      logic [511:0]  a, b;
      logic [1023:0] prev, exp;
      tv[0].nm = "identity";
      tv[1].nm = "neg128_sq";
      tv[2].nm = "p127_n128";
      tv[3].nm = "random";
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            tv[0].a[(i*8+j)*8 +: 8]    = (i == j) ? 8'd1 : 8'd0;
            tv[0].b[(i*8+j)*8 +: 8]    = 8'(i*8 + j - 32);
            tv[0].exp[(i*8+j)*16 +: 16] = 16'(i*8 + j - 32);
         end
      tv[0].exp[1023:1024-64*16] = tv[0].exp[1023:1024-64*16];
      tv[1].a = {64{8'h80}};
      tv[1].b = {64{8'h80}};
      tv[1].exp = {64{16'h0000}};
      tv[2].a = {64{8'h7f}};
      tv[2].b = {64{8'h80}};
      tv[2].exp = {64{16'h0400}};
      tv[3].a = rnd512();
      tv[3].b = rnd512();
      tv[3].exp = model(tv[3].a, tv[3].b, 8, 8, 8);

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      chk_int("reset_done", int'(done), 0);
      chk_mat("reset_result", rc, '0, 64);
      chk_int("reset_done_s", int'(done_s), 0);

      prev = '0;
      for (int v = 0; v < 4; v++) begin
         pulse(tv[v].a, tv[v].b);
         chk_int({tv[v].nm, "_done_drop"}, int'(done), 0);
         chk_mat({tv[v].nm, "_hold"}, rc, prev, 64);
         wait_done(lat);
         chk_int({tv[v].nm, "_latency"}, lat, 23);
         chk_mat(tv[v].nm, rc, tv[v].exp, 64);
         prev = tv[v].exp;
      end

      for (int r = 0; r < 3; r++) begin
         a = rnd512();
         b = rnd512();
         exp = model(a, b, 8, 8, 8);
         pulse(a, b);
         wait_done(lat);
         chk_int("b2b_latency", lat, 23);
         chk_mat("b2b_result", rc, exp, 64);
      end

      a = rnd512();
      b = rnd512();
      exp = model(a, b, 8, 8, 8);
      pulse(a, b);
      repeat (4) @(posedge clk);
      #1;
      pulse(rnd512(), rnd512());
      wait_done(lat);
      chk_int("restart_ignored_latency", lat, 18);
      chk_mat("restart_ignored_result", rc, exp, 64);

      pulse(rnd512(), rnd512());
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      chk_int("midrun_reset_done", int'(done), 0);
      chk_mat("midrun_reset_result", rc, '0, 64);
      a = rnd512();
      b = rnd512();
      exp = model(a, b, 8, 8, 8);
      pulse(a, b);
      wait_done(lat);
      chk_int("post_reset_latency", lat, 23);
      chk_mat("post_reset_result", rc, exp, 64);

      a = '0;
      b = '0;
      a[47:0] = rnd512() >> 464;
      b[95:0] = rnd512() >> 416;
      exp = model(a, b, 2, 3, 4);
      sa = a[47:0];
      sb = b[95:0];
      start_s = 1'b1;
      @(posedge clk);
      #1;
      start_s = 1'b0;
      sa = ~sa;
      lat = 0;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         #1;
         if (done_s) begin
            lat = c;
            break;
         end
      end
      chk_int("small_latency", lat, 8);
      chk_mat("small_result", {896'd0, rs}, exp, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
